// File: rtl/ir_prefetch_queue_if.sv
// Bus between the control unit / MBR side and the prefetching instruction register.
// The control unit drives CON and MBR_IN (master); the IR queue answers (slave).
interface ir_prefetch_queue_if #(
    parameter int WORD_W = 16,
    parameter int OP_W   = 8,
    parameter int DEPTH  = 4,
    parameter int CON_W  = 32
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [CON_W-1:0]       CON;
    logic [WORD_W-1:0]      MBR_IN;
    logic [OP_W-1:0]        IR_OUT;
    logic [WORD_W-OP_W-1:0] ADDR_OUT;
    logic                   IR_VALID;
    logic [CNT_W-1:0]       Q_COUNT;
    logic                   Q_FULL;
    logic                   Q_EMPTY;
    logic                   OVF;
    logic                   UNF;

    modport master (
        output CON, MBR_IN,
        input  IR_OUT, ADDR_OUT, IR_VALID, Q_COUNT, Q_FULL, Q_EMPTY, OVF, UNF
    );

    modport slave (
        input  CON, MBR_IN,
        output IR_OUT, ADDR_OUT, IR_VALID, Q_COUNT, Q_FULL, Q_EMPTY, OVF, UNF
    );
endinterface

// File: rtl/ir_prefetch_queue.sv
// Instruction register fed by a DEPTH-entry prefetch FIFO from the MBR.
// State changes on the falling clock edge; RST clears everything asynchronously.
// Flush (branch) wins over pop/push; pop on an empty queue with a concurrent
// push bypasses the FIFO straight into the IR.
module ir_prefetch_queue #(
    parameter int WORD_W    = 16,
    parameter int OP_W      = 8,
    parameter int DEPTH     = 4,
    parameter int CON_W     = 32,
    parameter int PUSH_BIT  = 2,
    parameter int POP_BIT   = 3,
    parameter int FLUSH_BIT = 6
) (
    input  logic              CLK,
    input  logic              RST,
    ir_prefetch_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WORD_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_rptr;
    logic [PTR_W-1:0]  r_wptr;
    logic [CNT_W-1:0]  r_count;
    logic [WORD_W-1:0] r_ir;
    logic              r_ir_valid;
    logic              r_ovf;
    logic              r_unf;

    logic              w_push;
    logic              w_pop;
    logic              w_flush;
    logic              w_empty;
    logic              w_full;
    logic              w_do_pop;
    logic              w_do_push;
    logic              w_bypass;
    logic              w_set_ovf;
    logic              w_set_unf;
    logic              w_wr_en;
    logic [PTR_W-1:0]  w_wr_idx;
    logic              w_unused_con;

    assign w_push  = bus.CON[PUSH_BIT];
    assign w_pop   = bus.CON[POP_BIT];
    assign w_flush = bus.CON[FLUSH_BIT];
    // Only three control bits belong to this block; the rest of CON is ignored.
    assign w_unused_con = ^bus.CON;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(DEPTH));

    // A pop on a full queue frees the head, so a simultaneous push still fits.
    // A bypass consumes the pushed word directly, so it never enters the FIFO.
    assign w_do_pop  = !w_flush && w_pop && !w_empty;
    assign w_bypass  = !w_flush && w_pop && w_empty && w_push;
    assign w_set_unf = !w_flush && w_pop && w_empty && !w_push;
    assign w_do_push = !w_flush && w_push && !w_bypass && (!w_full || w_pop);
    assign w_set_ovf = !w_flush && w_push && w_full && !w_pop;

    // Branch-target fetch after a flush always lands in slot 0.
    assign w_wr_en  = (w_flush && w_push) || w_do_push;
    assign w_wr_idx = w_flush ? '0 : r_wptr;

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(negedge CLK) begin
        if (w_wr_en) r_mem[w_wr_idx] <= bus.MBR_IN;
    end

    // Read/write pointers and occupancy.
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else if (w_flush) begin
            r_rptr  <= '0;
            r_wptr  <= w_push ? PTR_W'(1) : '0;
            r_count <= w_push ? CNT_W'(1) : '0;
        end else begin
            if (w_do_pop)  r_rptr <= r_rptr + PTR_W'(1);
            if (w_do_push) r_wptr <= r_wptr + PTR_W'(1);
            if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
            else if (w_do_pop && !w_do_push) r_count <= r_count - CNT_W'(1);
        end
    end

    // Instruction register: loads from the FIFO head or bypasses from MBR_IN.
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            r_ir       <= '0;
            r_ir_valid <= 1'b0;
        end else if (w_flush) begin
            r_ir_valid <= 1'b0;
        end else if (w_do_pop) begin
            r_ir       <= r_mem[r_rptr];
            r_ir_valid <= 1'b1;
        end else if (w_bypass) begin
            r_ir       <= bus.MBR_IN;
            r_ir_valid <= 1'b1;
        end
    end

    // Sticky error flags; only reset clears them, a flush does not.
    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_set_ovf) r_ovf <= 1'b1;
            if (w_set_unf) r_unf <= 1'b1;
        end
    end

    assign bus.IR_OUT   = r_ir[WORD_W-1 -: OP_W];
    assign bus.ADDR_OUT = r_ir[WORD_W-OP_W-1:0];
    assign bus.IR_VALID = r_ir_valid;
    assign bus.Q_COUNT  = r_count;
    assign bus.Q_FULL   = w_full;
    assign bus.Q_EMPTY  = w_empty;
    assign bus.OVF      = r_ovf;
    assign bus.UNF      = r_unf;
endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Scoreboard bench for ir_prefetch_queue: each directed step queues its
// hand-computed expected state; a monitor checks it after the falling edge.
module tb_ir_prefetch_queue;
    logic CLK = 1'b0;
    logic RST = 1'b0;

    ir_prefetch_queue_if #(.WORD_W(16), .OP_W(8), .DEPTH(4), .CON_W(32)) bus ();

    ir_prefetch_queue #(
        .WORD_W(16), .OP_W(8), .DEPTH(4), .CON_W(32),
        .PUSH_BIT(2), .POP_BIT(3), .FLUSH_BIT(6)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic [15:0] ir;
        logic        v;
        int          cnt;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_state(input exp_t e);
        chk({e.name, ".ir"},    32'(bus.IR_OUT),   32'(e.ir[15:8]));
        chk({e.name, ".addr"},  32'(bus.ADDR_OUT), 32'(e.ir[7:0]));
        chk({e.name, ".valid"}, 32'(bus.IR_VALID), 32'(e.v));
        chk({e.name, ".count"}, 32'(bus.Q_COUNT),  32'(e.cnt));
        chk({e.name, ".full"},  32'(bus.Q_FULL),   32'(e.cnt == 4));
        chk({e.name, ".empty"}, 32'(bus.Q_EMPTY),  32'(e.cnt == 0));
        chk({e.name, ".ovf"},   32'(bus.OVF),      32'(e.ovf));
        chk({e.name, ".unf"},   32'(bus.UNF),      32'(e.unf));
    endtask

    // Monitor: state settles on the falling edge; check shortly after it.
    initial begin
        forever begin
            @(negedge CLK);
            #2;
            if (exp_q.size() > 0) chk_state(exp_q.pop_front());
        end
    end

    // One control-word cycle: drive between falling edges, queue the expected result.
    task automatic step(input string nm, input bit push, input bit pop, input bit flush,
                        input logic [15:0] d, input logic [15:0] e_ir, input bit e_v,
                        input int e_cnt, input bit e_ovf, input bit e_unf);
        exp_t e;
        @(posedge CLK);
        bus.CON       = '0;
        bus.CON[2]    = push;
        bus.CON[3]    = pop;
        bus.CON[6]    = flush;
        bus.MBR_IN    = d;
        e.name = nm; e.ir = e_ir; e.v = e_v; e.cnt = e_cnt; e.ovf = e_ovf; e.unf = e_unf;
        exp_q.push_back(e);
    endtask

    // Asynchronous reset pulse placed between edges, checked before any clock edge.
    task automatic mid_reset(input string nm);
        exp_t z;
        @(posedge CLK);
        bus.CON = '0;
        #2 RST = 1'b1;
        #1;
        z.name = nm; z.ir = 16'h0; z.v = 1'b0; z.cnt = 0; z.ovf = 1'b0; z.unf = 1'b0;
        chk_state(z);
        #1 RST = 1'b0;
    endtask

    initial begin
        bus.CON    = '0;
        bus.MBR_IN = '0;
        #1 RST = 1'b1;
        begin
            exp_t z;
            #1;
            z.name = "reset"; z.ir = 16'h0; z.v = 1'b0; z.cnt = 0; z.ovf = 1'b0; z.unf = 1'b0;
            chk_state(z);
        end
        #2 RST = 1'b0;

        // 1: three pushes, one pop
        step("t1.push0", 1, 0, 0, 16'h1234, 16'h0000, 0, 1, 0, 0);
        step("t1.push1", 1, 0, 0, 16'hAB01, 16'h0000, 0, 2, 0, 0);
        step("t1.push2", 1, 0, 0, 16'h7F80, 16'h0000, 0, 3, 0, 0);
        step("t1.pop",   0, 1, 0, 16'h0000, 16'h1234, 1, 2, 0, 0);

        // 2: flush, fill, overflow, drain, underflow
        step("t2.flush", 0, 0, 1, 16'h0000, 16'h1234, 0, 0, 0, 0);
        step("t2.push0", 1, 0, 0, 16'h1111, 16'h1234, 0, 1, 0, 0);
        step("t2.push1", 1, 0, 0, 16'h2222, 16'h1234, 0, 2, 0, 0);
        step("t2.push2", 1, 0, 0, 16'h3333, 16'h1234, 0, 3, 0, 0);
        step("t2.push3", 1, 0, 0, 16'h4444, 16'h1234, 0, 4, 0, 0);
        step("t2.ovf",   1, 0, 0, 16'h5555, 16'h1234, 0, 4, 1, 0);
        step("t2.pop0",  0, 1, 0, 16'h0000, 16'h1111, 1, 3, 1, 0);
        step("t2.pop1",  0, 1, 0, 16'h0000, 16'h2222, 1, 2, 1, 0);
        step("t2.pop2",  0, 1, 0, 16'h0000, 16'h3333, 1, 1, 1, 0);
        step("t2.pop3",  0, 1, 0, 16'h0000, 16'h4444, 1, 0, 1, 0);
        step("t2.unf",   0, 1, 0, 16'h0000, 16'h4444, 1, 0, 1, 1);

        // 3: push+pop on a full queue
        step("t3.push0", 1, 0, 0, 16'hA001, 16'h4444, 1, 1, 1, 1);
        step("t3.push1", 1, 0, 0, 16'hA002, 16'h4444, 1, 2, 1, 1);
        step("t3.push2", 1, 0, 0, 16'hA003, 16'h4444, 1, 3, 1, 1);
        step("t3.push3", 1, 0, 0, 16'hA004, 16'h4444, 1, 4, 1, 1);
        step("t3.pushpop", 1, 1, 0, 16'h9900, 16'hA001, 1, 4, 1, 1);
        step("t3.pop0",  0, 1, 0, 16'h0000, 16'hA002, 1, 3, 1, 1);
        step("t3.pop1",  0, 1, 0, 16'h0000, 16'hA003, 1, 2, 1, 1);
        step("t3.pop2",  0, 1, 0, 16'h0000, 16'hA004, 1, 1, 1, 1);
        step("t3.pop3",  0, 1, 0, 16'h0000, 16'h9900, 1, 0, 1, 1);

        // 4: bypass on an empty queue (fresh reset so UNF starts clear)
        mid_reset("t4.reset");
        step("t4.bypass", 1, 1, 0, 16'hC3A5, 16'hC3A5, 1, 0, 0, 0);

        // 5: flush with branch-target push; flush masks pop
        step("t5.push0", 1, 0, 0, 16'h1010, 16'hC3A5, 1, 1, 0, 0);
        step("t5.push1", 1, 0, 0, 16'h2020, 16'hC3A5, 1, 2, 0, 0);
        step("t5.flushpush", 1, 0, 1, 16'h4020, 16'hC3A5, 0, 1, 0, 0);
        step("t5.pop",   0, 1, 0, 16'h0000, 16'h4020, 1, 0, 0, 0);
        step("t5.flushpop", 0, 1, 1, 16'h0000, 16'h4020, 0, 0, 0, 0);

        // 6: get count=3 with OVF set, reset mid-cycle, then exercise pointer wrap
        step("t6.push0", 1, 0, 0, 16'h0101, 16'h4020, 0, 1, 0, 0);
        step("t6.push1", 1, 0, 0, 16'h0202, 16'h4020, 0, 2, 0, 0);
        step("t6.push2", 1, 0, 0, 16'h0303, 16'h4020, 0, 3, 0, 0);
        step("t6.push3", 1, 0, 0, 16'h0404, 16'h4020, 0, 4, 0, 0);
        step("t6.ovf",   1, 0, 0, 16'h0505, 16'h4020, 0, 4, 1, 0);
        step("t6.pop",   0, 1, 0, 16'h0000, 16'h0101, 1, 3, 1, 0);
        mid_reset("t6.reset");
        step("t6.w0",    1, 0, 0, 16'hB001, 16'h0000, 0, 1, 0, 0);
        step("t6.w1",    1, 0, 0, 16'hB002, 16'h0000, 0, 2, 0, 0);
        step("t6.w2",    1, 0, 0, 16'hB003, 16'h0000, 0, 3, 0, 0);
        step("t6.wp3",   1, 1, 0, 16'hB004, 16'hB001, 1, 3, 0, 0);
        step("t6.wp4",   1, 1, 0, 16'hB005, 16'hB002, 1, 3, 0, 0);
        step("t6.r2",    0, 1, 0, 16'h0000, 16'hB003, 1, 2, 0, 0);
        step("t6.r3",    0, 1, 0, 16'h0000, 16'hB004, 1, 1, 0, 0);
        step("t6.r4",    0, 1, 0, 16'h0000, 16'hB005, 1, 0, 0, 0);

        @(posedge CLK);
        bus.CON = '0;
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge CLK);
        end
        if (exp_q.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: %0d expected entries left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
